// File: rtl/cpu_sequencer.sv
// Control unit with program counter for the small-CPU datapath: fetch/decode,
// return-address stack (CALL/RET), interrupt entry/exit and a user-memory wait state.
module cpu_sequencer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned RSEL_W      = 2,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_VEC   = 0,
  parameter int unsigned IRQ_VEC     = 'hFE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              irq,
  output logic              irq_ack,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [RSEL_W-1:0] rf_raddr1,
  output logic [RSEL_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [RSEL_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] umem_addr,
  output logic [DATA_W-1:0] umem_wdata,
  output logic              umem_we,
  output logic              umem_re,
  input  logic [DATA_W-1:0] umem_rdata,
  output logic              stack_err
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] IRQ_PC  = ADDR_W'(IRQ_VEC);
  localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_IRQ} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] ir;
  logic [SP_W-1:0]   sp;
  logic              ie;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic [3:0]        op;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc_inc;
  logic              done;
  logic              take_irq;

  assign op       = ir[DATA_W-1 -: 4];
  assign operand  = imem_rdata[ADDR_W-1:0];
  assign pc_inc   = pc + ADDR_W'(1);
  // Interrupts are only considered on the cycle that completes an instruction.
  assign done     = ((state == S_EXEC) && (op != 4'hF)) || (state == S_MEM);
  assign take_irq = done && irq && ie;

  assign imem_addr  = pc;
  assign alu_op     = op;
  assign rf_raddr1  = ir[2*RSEL_W-1:RSEL_W];
  assign rf_raddr2  = ir[RSEL_W-1:0];
  assign rf_waddr   = ir[RSEL_W-1:0];
  assign umem_wdata = rf_rdata1;

  // Sequencer state, program counter, instruction register and return stack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      pc        <= RST_PC;
      maddr     <= '0;
      ir        <= '0;
      sp        <= '0;
      ie        <= 1'b1;
      stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= imem_rdata;
          pc    <= pc_inc;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= take_irq ? S_IRQ : S_FETCH;
          case (op)
            4'h8, 4'hE: pc <= pc_inc;
            4'h9:       pc <= operand;
            4'hA: begin
              // Full stack drops the return address but the call still happens.
              if (sp == SP_FULL) begin
                stack_err <= 1'b1;
              end else begin
                stack[IDX_W'(sp)] <= pc_inc;
                sp                <= sp + SP_W'(1);
              end
              pc <= operand;
            end
            4'hB: begin
              if (sp == '0) begin
                pc        <= RST_PC;
                stack_err <= 1'b1;
              end else begin
                pc <= stack[IDX_W'(sp - SP_W'(1))];
                sp <= sp - SP_W'(1);
              end
              if (ir[0]) ie <= 1'b1;
            end
            4'hC: pc <= (rf_rdata1 == rf_rdata2) ? operand : pc_inc;
            4'hD: pc <= (rf_rdata1 != rf_rdata2) ? operand : pc_inc;
            4'hF: begin
              pc    <= pc_inc;
              maddr <= operand;
              state <= S_MEM;
            end
            default: ;
          endcase
        end
        S_MEM: state <= take_irq ? S_IRQ : S_FETCH;
        S_IRQ: begin
          if (sp == SP_FULL) begin
            stack_err <= 1'b1;
          end else begin
            stack[IDX_W'(sp)] <= pc;
            sp                <= sp + SP_W'(1);
          end
          pc    <= IRQ_PC;
          ie    <= 1'b0;
          state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Strobe and data-path decode from the current state and instruction.
  always_comb begin
    irq_ack   = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = alu_result;
    umem_we   = 1'b0;
    umem_re   = 1'b0;
    umem_addr = operand;
    case (state)
      S_EXEC: begin
        if (op[3] == 1'b0) rf_we = 1'b1;
        case (op)
          4'h8: begin
            rf_we    = 1'b1;
            rf_wdata = imem_rdata;
          end
          4'hE:    umem_we = 1'b1;
          4'hF:    umem_re = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        rf_we     = 1'b1;
        rf_wdata  = umem_rdata;
        umem_addr = maddr;
      end
      S_IRQ:   irq_ack = 1'b1;
      default: ;
    endcase
  end

endmodule
